// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the sync FIFO: pops burst_len words and replays them
// as a valid/ready stream through a 2-entry buffer that hides the FIFO read latency.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [LEN_WIDTH-1:0]  r_issue_left;
    logic [LEN_WIDTH-1:0]  r_deliver_left;
    logic                  r_inflight;
    logic [1:0]            r_buf_count;
    logic [DATA_WIDTH-1:0] r_buf_0;
    logic [DATA_WIDTH-1:0] r_buf_1;

    logic                  w_accept;
    logic                  w_start_burst;
    logic [2:0]            w_slots_used;
    logic                  w_rd_en;

    // Handshake, occupancy and pop qualifier
    always_comb begin
        w_accept      = (r_buf_count != 2'd0) && out_ready;
        w_start_burst = (r_state == ST_IDLE) && start && (burst_len != {LEN_WIDTH{1'b0}});
        // A word leaving this cycle frees its slot, which keeps the stream at one word per cycle.
        w_slots_used  = {1'b0, r_buf_count} + {2'b00, r_inflight} - {2'b00, w_accept};
        w_rd_en       = (r_state == ST_RUN) && (r_issue_left != {LEN_WIDTH{1'b0}}) &&
                        !fifo_empty && (w_slots_used < 3'd2);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len != {LEN_WIDTH{1'b0}}) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_accept && (r_deliver_left == {{(LEN_WIDTH-1){1'b0}}, 1'b1})) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy       = (r_state == ST_RUN);
        done       = (r_state == ST_DONE);
        fifo_rd_en = w_rd_en;
        out_valid  = (r_buf_count != 2'd0);
        out_data   = r_buf_0;
    end

    // Counters, in-flight flag and the 2-entry output buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_left   <= {LEN_WIDTH{1'b0}};
            r_deliver_left <= {LEN_WIDTH{1'b0}};
            r_inflight     <= 1'b0;
            r_buf_count    <= 2'd0;
            r_buf_0        <= {DATA_WIDTH{1'b0}};
            r_buf_1        <= {DATA_WIDTH{1'b0}};
        end else begin
            if (w_start_burst) begin
                r_issue_left   <= burst_len;
                r_deliver_left <= burst_len;
            end else begin
                if (w_rd_en) begin
                    r_issue_left <= r_issue_left - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                end
                if (w_accept) begin
                    r_deliver_left <= r_deliver_left - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            r_inflight <= w_rd_en;
            case ({r_inflight, w_accept})
                2'b10: begin
                    if (r_buf_count == 2'd0) begin
                        r_buf_0 <= fifo_data;
                    end else begin
                        r_buf_1 <= fifo_data;
                    end
                    r_buf_count <= r_buf_count + 2'd1;
                end
                2'b01: begin
                    r_buf_0     <= r_buf_1;
                    r_buf_count <= r_buf_count - 2'd1;
                end
                2'b11: begin
                    if (r_buf_count == 2'd1) begin
                        r_buf_0 <= fifo_data;
                    end else begin
                        r_buf_0 <= r_buf_1;
                        r_buf_1 <= fifo_data;
                    end
                end
                default: begin
                    r_buf_count <= r_buf_count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural sync FIFO
// (registered data_out, empty updated on the pop edge).
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy, done, fifo_rd_en, out_valid;
    logic [DW-1:0] out_data;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          out_ready = 1'b0;

    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          fifo_clr = 1'b0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];
    int            pops = 0;
    int            underflows = 0;
    int            dones = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // FIFO model and stream monitor
    always @(posedge clk) begin
        if (fifo_clr) begin
            q.delete();
        end else begin
            if (fifo_rd_en && q.size() > 0) fifo_data <= q.pop_front();
            if (wr_en) q.push_back(wr_data);
        end
        fifo_empty <= (q.size() == 0);
        if (reset) begin
            pops       <= pops + int'(fifo_rd_en);
            underflows <= underflows + int'(fifo_rd_en && fifo_empty);
            dones      <= dones + int'(done);
            if (out_valid && out_ready) got.push_back(out_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + DW'(i);
            step();
        end
        wr_en = 1'b0;
        step();
    endtask

    task automatic fifo_clear();
        fifo_clr = 1'b1;
        step();
        fifo_clr = 1'b0;
        step();
    endtask

    task automatic do_start(input int len);
        start     = 1'b1;
        burst_len = LW'(len);
        step();
        start     = 1'b0;
    endtask

    // Runs from the current sample point until done; sample index 0 is the call point.
    task automatic run_burst(input int maxc, output int first_v, output int done_at,
                             output int rd_first, output int rd_last);
        first_v = -1; done_at = -1; rd_first = -1; rd_last = -1;
        for (int c = 0; c < maxc; c++) begin
            if (out_valid && first_v < 0) first_v = c;
            if (fifo_rd_en) begin
                if (rd_first < 0) rd_first = c;
                rd_last = c;
            end
            if (done) begin
                done_at = c;
                break;
            end
            step();
        end
    endtask

    int fv, da, rf, rl, base, p0, d0, busy_bad;

    initial begin
        // Reset state
        step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        reset = 1'b1;
        step();
        check_eq("rst_done", done, 0);

        // 1: 8-word burst, sink always ready
        out_ready = 1'b1;
        preload(8'h10, 8);
        base = got.size(); p0 = pops; d0 = dones;
        do_start(8);
        check_eq("t1_busy", busy, 1);
        run_burst(40, fv, da, rf, rl);
        check_eq("t1_first_valid", fv, 2);
        check_eq("t1_done_at", da, 10);
        check_eq("t1_rd_first", rf, 0);
        check_eq("t1_rd_last", rl, 7);
        check_eq("t1_busy_at_done", busy, 0);
        step();
        check_eq("t1_pops", pops - p0, 8);
        check_eq("t1_dones", dones - d0, 1);
        check_eq("t1_fifo_left", q.size(), 0);
        check_eq("t1_count", got.size() - base, 8);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("t1_word%0d", i), got[base + i], 32'h10 + i);

        // 2: backpressure, 5 stalled cycles
        preload(8'hA0, 6);
        out_ready = 1'b0;
        base = got.size(); p0 = pops; d0 = dones;
        do_start(4);
        for (int c = 0; c < 4; c++) step();
        check_eq("t2_stall_pops", pops - p0, 2);
        check_eq("t2_stall_rd_en", fifo_rd_en, 0);
        check_eq("t2_stall_valid", out_valid, 1);
        check_eq("t2_stall_data", out_data, 32'hA0);
        out_ready = 1'b1;
        run_burst(40, fv, da, rf, rl);
        check_eq("t2_done_seen", (da >= 0), 1);
        step();
        check_eq("t2_pops", pops - p0, 4);
        check_eq("t2_fifo_left", q.size(), 2);
        check_eq("t2_count", got.size() - base, 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t2_word%0d", i), got[base + i], 32'hA0 + i);
        fifo_clear();

        // 3: starved FIFO, writer trickles words in
        base = got.size(); p0 = pops; busy_bad = 0; da = -1;
        do_start(3);
        for (int c = 0; c < 40; c++) begin
            wr_en   = (c == 4) || (c == 9) || (c == 10);
            wr_data = (c == 4) ? 8'h01 : ((c == 9) ? 8'h02 : 8'h03);
            if (done) begin
                da = c;
                break;
            end
            if (!busy) busy_bad++;
            step();
        end
        wr_en = 1'b0;
        check_eq("t3_done_at", da, 14);
        check_eq("t3_busy", busy_bad, 0);
        step();
        check_eq("t3_pops", pops - p0, 3);
        check_eq("t3_count", got.size() - base, 3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("t3_word%0d", i), got[base + i], 32'h01 + i);
        check_eq("t3_underflow", underflows, 0);

        // 4: zero-length burst
        p0 = pops; d0 = dones;
        do_start(0);
        check_eq("t4_done", done, 1);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_rd_en", fifo_rd_en, 0);
        step();
        check_eq("t4_done_clear", done, 0);
        check_eq("t4_pops", pops - p0, 0);
        check_eq("t4_dones", dones - d0, 1);

        // 5: start re-pulsed mid-burst is ignored
        preload(8'h30, 6);
        base = got.size(); p0 = pops;
        do_start(3);
        start = 1'b1; burst_len = LW'(5);
        step();
        start = 1'b0;
        run_burst(40, fv, da, rf, rl);
        check_eq("t5_done_at", da, 4);
        step();
        check_eq("t5_pops", pops - p0, 3);
        check_eq("t5_fifo_left", q.size(), 3);
        check_eq("t5_count", got.size() - base, 3);
        check_eq("t5_last", got[base + 2], 32'h32);
        fifo_clear();

        // 6: async reset mid-burst, then a fresh 2-word burst
        preload(8'h40, 4);
        out_ready = 1'b0;
        do_start(4);
        step();
        step();
        #3 reset = 1'b0;
        #1;
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_valid", out_valid, 0);
        check_eq("t6_rst_data", out_data, 0);
        check_eq("t6_rst_rd_en", fifo_rd_en, 0);
        @(posedge clk); #1;
        fifo_clear();
        reset = 1'b1;
        out_ready = 1'b1;
        step();
        preload(8'h55, 2);
        base = got.size(); p0 = pops;
        do_start(2);
        run_burst(40, fv, da, rf, rl);
        check_eq("t6_done_at", da, 4);
        step();
        check_eq("t6_pops", pops - p0, 2);
        check_eq("t6_count", got.size() - base, 2);
        check_eq("t6_word0", got[base], 32'h55);
        check_eq("t6_word1", got[base + 1], 32'h56);
        check_eq("underflow_total", underflows, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
